// File: rtl/axis_frame_sched_pkg.sv
// Shared types and helpers for the frame-granular AXI-Stream scheduler.
package axis_frame_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  // Widest request vector the circular search supports.
  localparam int MAX_PORTS = 16;

  // Circular first-set-bit search starting at 'start'. Only the first
  // 'ports' bits are considered, so wrapping skips nonexistent indices.
  // Returns {found, index}.
  function automatic logic [4:0] rr_first_set(input logic [MAX_PORTS-1:0] req,
                                              input int start,
                                              input int ports);
    logic [4:0] res;
    int j;
    res = '0;
    for (int i = MAX_PORTS - 1; i >= 0; i--) begin
      if (i < ports) begin
        j = start + i;
        if (j >= ports) j = j - ports;
        if (req[j[3:0]]) res = {1'b1, j[3:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_frame_sched_if.sv
// Bundle of the per-port ingress streams, urgency hints and the shared egress stream.
interface axis_frame_sched_if #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1
);

  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata;
  logic [PORTS*KEEP_WIDTH-1:0] s_axis_tkeep;
  logic [PORTS-1:0]            s_axis_tvalid;
  logic [PORTS-1:0]            s_axis_tready;
  logic [PORTS-1:0]            s_axis_tlast;
  logic [PORTS*USER_WIDTH-1:0] s_axis_tuser;
  logic [PORTS-1:0]            s_urgent;

  logic [DATA_WIDTH-1:0]       m_axis_tdata;
  logic [KEEP_WIDTH-1:0]       m_axis_tkeep;
  logic                        m_axis_tvalid;
  logic                        m_axis_tready;
  logic                        m_axis_tlast;
  logic [USER_WIDTH-1:0]       m_axis_tuser;

  // Scheduler view: consumes the port streams, produces the egress stream.
  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    input  s_urgent, m_axis_tready,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );

  // Environment view: drives the port streams and sinks the egress stream.
  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    output s_urgent, m_axis_tready,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );

endinterface

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker: request vector + start index -> winner.
module axis_rr_pick
  import axis_frame_sched_pkg::*;
#(
  parameter int PORTS      = 4,
  parameter int CLOG_PORTS = $clog2(PORTS)
) (
  input  logic [PORTS-1:0]      req,
  input  logic [CLOG_PORTS-1:0] start,
  output logic [CLOG_PORTS-1:0] winner,
  output logic                  found
);

  logic [MAX_PORTS-1:0] req_ext;
  logic [4:0]           pick;

  // Zero-extend the request vector and run the circular search.
  always_comb begin
    req_ext            = '0;
    req_ext[PORTS-1:0] = req;
    pick               = rr_first_set(req_ext, int'(start), PORTS);
    found              = pick[4];
    winner             = pick[CLOG_PORTS-1:0];
  end

endmodule

// File: rtl/axis_frame_sched.sv
// Frame-granular scheduler sharing one AXI-Stream egress among PORTS inputs,
// with round-robin arbitration, an urgency tier and a starvation limiter.
module axis_frame_sched
  import axis_frame_sched_pkg::*;
#(
  parameter int PORTS        = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int USER_WIDTH   = 1,
  parameter int URGENT_LIMIT = 4,
  localparam int CLOG_PORTS  = $clog2(PORTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  axis_frame_sched_if.slave     bus,
  output logic [CLOG_PORTS-1:0] status_grant,
  output logic                  status_busy,
  output logic                  status_frame_done
);

  localparam int CNT_W = $clog2(URGENT_LIMIT + 1);
  localparam logic [CNT_W-1:0]      URG_MAX  = CNT_W'(URGENT_LIMIT);
  localparam logic [CLOG_PORTS-1:0] LAST_IDX = CLOG_PORTS'(PORTS - 1);

  state_t                state_q, state_d;
  logic [CLOG_PORTS-1:0] rr_ptr_q, rr_ptr_d;
  logic [CLOG_PORTS-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]      urgent_cnt_q, urgent_cnt_d;

  logic [CLOG_PORTS-1:0] u_win, n_win;
  logic                  u_found, n_found;
  logic                  last_fire;

  // Urgency tier only sees ports that are both requesting and nearly full.
  axis_rr_pick #(.PORTS(PORTS), .CLOG_PORTS(CLOG_PORTS)) u_pick_urgent (
    .req    (bus.s_axis_tvalid & bus.s_urgent),
    .start  (rr_ptr_q),
    .winner (u_win),
    .found  (u_found)
  );

  axis_rr_pick #(.PORTS(PORTS), .CLOG_PORTS(CLOG_PORTS)) u_pick_normal (
    .req    (bus.s_axis_tvalid),
    .start  (rr_ptr_q),
    .winner (n_win),
    .found  (n_found)
  );

  // State, pointer, grant and urgency-streak registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      urgent_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      urgent_cnt_q <= urgent_cnt_d;
    end
  end

  // Arbitrate once per frame in IDLE; leave XFER when the tlast beat transfers.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    urgent_cnt_d = urgent_cnt_q;
    case (state_q)
      IDLE: begin
        if (n_found) begin
          state_d = XFER;
          if (u_found && (urgent_cnt_q < URG_MAX)) begin
            grant_d      = u_win;
            urgent_cnt_d = urgent_cnt_q + CNT_W'(1);
          end else begin
            grant_d      = n_win;
            urgent_cnt_d = '0;
          end
          rr_ptr_d = (grant_d == LAST_IDX) ? '0 : grant_d + CLOG_PORTS'(1);
        end
      end
      XFER: begin
        if (last_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Passthrough mux from the granted port; only that port ever sees tready.
  always_comb begin
    bus.m_axis_tdata  = bus.s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
    bus.m_axis_tkeep  = bus.s_axis_tkeep[grant_q*KEEP_WIDTH +: KEEP_WIDTH];
    bus.m_axis_tuser  = bus.s_axis_tuser[grant_q*USER_WIDTH +: USER_WIDTH];
    bus.m_axis_tlast  = bus.s_axis_tlast[grant_q];
    bus.m_axis_tvalid = (state_q == XFER) && bus.s_axis_tvalid[grant_q];
    bus.s_axis_tready = '0;
    if (state_q == XFER) bus.s_axis_tready[grant_q] = bus.m_axis_tready;
    last_fire         = bus.m_axis_tvalid && bus.m_axis_tready && bus.m_axis_tlast;
  end

  assign status_grant      = grant_q;
  assign status_busy       = (state_q == XFER);
  assign status_frame_done = last_fire;

endmodule

// File: doc/axis_frame_sched.md
Name: axis_frame_sched

Overview:
- Frame-granular scheduler that shares one AXI-Stream output between PORTS input streams.
- Each input is normally fronted by an axis_fifo in FRAME_FIFO mode. That FIFO's status_almost_full feeds this block as an urgency hint.
- Grants are per frame: a granted port owns the output from its first beat until its tlast transfers.
- Arbitration is round-robin, with an urgency tier and a starvation limiter. The block sits between the per-port FIFOs and the shared egress path.

Parameters:
- PORTS, 4, number of input streams (2..16).
- DATA_WIDTH, 64, tdata width.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- USER_WIDTH, 1, tuser width.
- URGENT_LIMIT, 4, maximum consecutive urgency-tier grants before one normal round-robin grant is forced.
- CLOG_PORTS, $clog2(PORTS), width of the grant index (local).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- s_axis_tdata  in  PORTS*DATA_WIDTH  input data, port i in slice i.
- s_axis_tkeep  in  PORTS*KEEP_WIDTH  input keep.
- s_axis_tvalid  in  PORTS  input valid.
- s_axis_tready  out  PORTS  input ready.
- s_axis_tlast  in  PORTS  input last.
- s_axis_tuser  in  PORTS*USER_WIDTH  input user.
- s_urgent  in  PORTS  per-port urgency (upstream FIFO almost_full).
- m_axis_tdata  out  DATA_WIDTH  output data.
- m_axis_tkeep  out  KEEP_WIDTH  output keep.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  output last.
- m_axis_tuser  out  USER_WIDTH  output user.
- status_grant  out  CLOG_PORTS  index of the current or last granted port.
- status_busy  out  1  asserted while in XFER.
- status_frame_done  out  1  one-cycle pulse on each tlast transfer.

Behaviour:
- Clocking: single clock domain. Reset is synchronous, active-high.
- Reset values:
  - state=IDLE, rr_ptr=0, grant=0, urgent_cnt=0.
  - m_axis_tvalid=0, s_axis_tready=0, status_busy=0, status_frame_done=0, status_grant=0.
- State IDLE:
  - Request vector req = s_axis_tvalid.
  - If req==0, stay in IDLE.
  - Otherwise, in the same cycle, select a winner and register grant. Go to XFER next cycle. Arbitration latency is 1 cycle from IDLE-with-request to first output valid.
- Winner selection:
  - ureq = req & s_urgent.
  - If ureq!=0 and urgent_cnt<URGENT_LIMIT: pick the first set bit of ureq at or after rr_ptr (circular), then urgent_cnt++.
  - Else: pick the first set bit of req at or after rr_ptr (circular), then urgent_cnt=0.
  - In both cases rr_ptr <= winner+1, wrapping at PORTS.
- State XFER, datapath is combinational passthrough:
  - m_axis_* = s_axis_*[grant].
  - m_axis_tvalid = s_axis_tvalid[grant].
  - s_axis_tready[grant] = m_axis_tready. All other tready bits are 0.
  - Bubbles (granted tvalid low mid-frame) do not release the grant.
- Frame end:
  - On a transfer (valid & ready) with tlast: pulse status_frame_done and go to IDLE.
  - There is no back-to-back re-arbitration in the same cycle, so there is a minimum 1 idle cycle between frames.
- Single-beat frame (tlast on first beat): legal. XFER lasts 1 cycle.
- Only one requester: it is granted every time. rr_ptr still advances.
- PORTS not a power of 2: the rr_ptr wrap must skip nonexistent indices.
- s_urgent and tvalid changes during XFER: ignored until the next IDLE.
- Reset mid-frame: on the next edge, outputs drop and the grant is lost. Upstream sees tready low; it may resend or truncate as it sees fit.
- status_grant holds the last winner while in IDLE.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=0, XFER=1);
  - a function for circular first-set-bit from a start index.
- Natural sub-module: axis_rr_pick. It is combinational: request vector + start index -> winner index + found flag. It is instantiated twice (urgent and normal tiers).
- FSM, counters and datapath mux stay in axis_frame_sched.

Test Plan:
- Round-robin fairness:
  - Stimulus: PORTS=4; all ports continuously offer 3-beat frames; s_urgent=0; m_axis_tready=1.
  - Required: grant order 0,1,2,3,0,...; each frame takes 3 XFER cycles + 1 IDLE cycle; 4 status_frame_done pulses per 16 cycles.
- Urgency tier:
  - Stimulus: s_urgent=4'b0100, all ports requesting.
  - Required: port 2 is granted 4 consecutive times (URGENT_LIMIT=4), then one normal RR grant (port 3), then port 2 again.
- Backpressure and bubbles:
  - Stimulus: m_axis_tready toggles 1,0,1,0 and the granted port drops tvalid mid-frame.
  - Required: no beat lost or duplicated; other ports' tready stays 0; the grant holds until tlast transfers.
- Single-beat frames and sparse requests:
  - Stimulus: only port 3 requests, with 1-beat frames.
  - Required: grant=3 every frame; output valid 1 cycle after each IDLE request; rr_ptr wraps to 0.
- Reset mid-frame:
  - Stimulus: assert rst in the 2nd beat of a 5-beat frame from port 1.
  - Required: the next cycle has m_axis_tvalid=0, s_axis_tready=0, status_busy=0; after release, arbitration restarts from rr_ptr=0 (port 0 wins if requesting).
